sram_stream_reader: RTL and testbench
=====================================

// Module: sram_stream_reader
// PURPOSE
//  Read-side master for sp_sram. Reads LEN words starting at BASE, one word per cycle, and
//  emits them in address order as a valid/ready stream with a last-beat marker.
//  Absorbs the SRAM's fixed 1-cycle read latency and downstream backpressure with a 2-entry buffer.
//  Sits between sp_sram (port addr_o/douta) and downstream stream consumers. It complements the 4-word burst writer.
// PARAMETERS
//  WIDTH  10                 data word width; must match sp_sram WIDTH
//  DEPTH  128                SRAM depth in words; must match sp_sram DEPTH
//  ADDRB  $clog2(DEPTH)      address width
// PORTS
//  clk         in   1         single clock, all logic on posedge
//  rst_n       in   1         synchronous reset, active-low
//  start       in   1         1-cycle request; sampled only in IDLE
//  abort       in   1         cancel current transfer; ignored in IDLE
//  base_addr   in   ADDRB     first word address, sampled with start
//  length      in   ADDRB+1   words to read, sampled with start; 0 allowed
//  busy        out  1         high from accepted start until done/abort
//  done        out  1         1-cycle pulse after the last beat handshakes
//  mem_ena     out  1         to sp_sram ena
//  mem_rea     out  1         to sp_sram rea
//  mem_addr_o  out  ADDRB     to sp_sram addr_o
//  mem_douta   in   WIDTH     from sp_sram douta; valid 1 cycle after mem_rea
//  m_valid     out  1         stream beat valid
//  m_data      out  WIDTH     stream beat data
//  m_last      out  1         marks beat number length-1
//  m_ready     in   1         downstream accept; handshake = m_valid & m_ready
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE. busy, done, mem_ena, mem_rea, m_valid and m_last are 0.
//   mem_addr_o and m_data are 0. Buffer is emptied; any in-flight read is discarded.
//  FSM: IDLE -> RUN on start when length!=0. IDLE -> IDLE on start when length==0; done pulses next cycle, busy stays 0.
//   RUN -> DRAIN when the final read issues. DRAIN -> IDLE when the last beat handshakes; done=1 that cycle+1.
//   Any state other than IDLE -> IDLE on abort. On abort: buffer is flushed, the in-flight read is dropped, and done is not pulsed.
//   abort takes priority over a handshake in the same cycle.
//  Read issue: mem_rea=mem_ena=1 in a cycle only if RUN and (buffer occupancy + reads in flight) < 2.
//   This guarantees no returning word is ever lost.
//  Addressing: word i is read at (base_addr+i) mod DEPTH. Wrap is explicit, which also covers non-power-of-2 DEPTH.
//   mem_addr_o is never >= DEPTH.
//  Read counter is ADDRB+1 bits. Its terminal value is length. m_last=1 exactly on beat length-1.
//  Latency: with m_ready held at 1, the first beat appears 2 cycles after start, and throughput is 1 beat/cycle.
//  Buffer: 2-entry FIFO storing {last,data}. The head drives m_valid/m_data/m_last.
//   Push and pop in the same cycle are legal at any occupancy the credit rule allows.
//  m_data and m_last hold stable while m_valid=1 and m_ready=0.
//  start while busy is ignored. A start that coincides with done (back in IDLE) is accepted.
//  Reset mid-transfer behaves as abort plus full register clear.
// STRUCTURE
//  Package sram_stream_pkg:
//   - state encodings IDLE/RUN/DRAIN
//   - localparam RD_LAT=1
//   - localparam BUF_DEPTH=2
//  Sub-module sync_fifo2: 2-entry synchronous FIFO (push, pop, full, empty, flush).
//   It is reused for {last,data} storage.
//  Top level contains the FSM, the issue counter, the in-flight flag, the credit logic and the address wrap.
// TESTING
//  Bench pairs this block with a real sp_sram instance preloaded with mem[k]=k+100.
//  1) base=5, len=4, m_ready=1 -> data 105,106,107,108 on 4 consecutive cycles; m_last on 108;
//     done one cycle after the last beat.
//  2) DEPTH=128, base=126, len=4 -> addresses 126,127,0,1; data 226,227,100,101; mem_addr_o never >=128.
//  3) len=8 with m_ready toggling 1,0,0,1,... -> all 8 words in order with no loss or duplicates;
//     data stays stable while stalled; mem_rea stops when buffer+in-flight=2.
//  4) len=0 -> no m_valid and no mem_rea; done pulses once; busy stays 0.
//  5) len=10, abort after the 3rd beat -> m_valid drops the next cycle; no done; busy=0;
//     a new start base=0, len=2 then yields 100,101.
//  6) rst_n=0 mid-transfer with m_ready=0 and the buffer full -> all outputs at reset values next cycle;
//     the old data never appears afterwards.

Source files
------------

// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for the SRAM stream reader.
//   state_e    : reader FSM states
//   RD_LAT     : SRAM read latency in cycles
//   BUF_DEPTH  : output buffer entries
package sram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/sram_stream_reader_fifo2.sv
// Two-entry synchronous FIFO used as the reader's output buffer.
//   clk, rst_n : clock, synchronous active-low reset (clears storage too)
//   flush_i    : empties the FIFO, overriding push/pop
//   push_i     : write din_i (accepted when not full, or when popping)
//   pop_i      : drop the head entry
//   dout_o     : head entry
//   full_o     : two entries held
//   empty_o    : no entries held
module sync_fifo2
  import sram_stream_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [BUF_DEPTH];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == 2'(BUF_DEPTH));
  assign empty_o = (cnt_q == 2'd0);
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Read-side master for sp_sram: reads `length` words from `base_addr`
// (wrapping modulo DEPTH) and streams them out in order with a last marker.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, base_addr,
//   length                : transfer request (sampled in IDLE only)
//   abort                 : cancel transfer, flush buffer, no done pulse
//   busy, done            : transfer active / 1-cycle completion pulse
//   mem_ena, mem_rea,
//   mem_addr_o, mem_douta : sp_sram read port (1-cycle latency)
//   m_valid, m_data,
//   m_last, m_ready       : output stream
module sram_stream_reader
  import sram_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned ADDRB = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ADDRB-1:0] base_addr,
  input  logic [ADDRB:0]   length,
  output logic             busy,
  output logic             done,
  output logic             mem_ena,
  output logic             mem_rea,
  output logic [ADDRB-1:0] mem_addr_o,
  input  logic [WIDTH-1:0] mem_douta,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  state_e           state_q, state_d;
  logic [ADDRB:0]   cnt_q, cnt_d;
  logic [ADDRB:0]   len_q, len_d;
  logic [ADDRB-1:0] addr_q, addr_d;
  logic             infl_q, infl_d;
  logic             infl_last_q, infl_last_d;
  logic             done_q, done_d;

  logic             issue;
  logic             f_flush, f_push, f_pop, f_full, f_empty;
  logic [WIDTH:0]   f_din, f_dout;
  logic [1:0]       occ, credit_sum;
  logic             hs;

  sync_fifo2 #(.W(WIDTH + 1)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (f_flush),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .din_i   (f_din),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign m_valid          = ~f_empty;
  assign {m_last, m_data} = f_dout;
  assign hs               = m_valid & m_ready;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign mem_ena          = issue;
  assign mem_rea          = issue;
  assign mem_addr_o       = addr_q;

  // Occupancy counts the head leaving this cycle as already gone; without
  // that, steady streaming would stall every other cycle. A word is still
  // never lost: whatever is issued now lands in a slot freed by this pop.
  assign occ        = f_full ? 2'd2 : (f_empty ? 2'd0 : 2'd1);
  assign credit_sum = occ - 2'(f_pop) + 2'(infl_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    done_d      = 1'b0;
    issue       = 1'b0;
    f_flush     = 1'b0;
    f_pop       = hs & ~abort;
    f_push      = infl_q & ~abort;
    f_din       = {infl_last_q, mem_douta};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = RUN;
            len_d   = length;
            cnt_d   = '0;
            addr_d  = base_addr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          f_flush = 1'b1;
        end else if (credit_sum < 2'd2) begin
          issue       = 1'b1;
          infl_d      = 1'b1;
          infl_last_d = (cnt_q == len_q - 1'b1);
          cnt_d       = cnt_q + 1'b1;
          addr_d      = (addr_q == ADDRB'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          f_flush = 1'b1;
        end else if (hs && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
module tb_sram_stream_reader;
  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned ADDRB = 7;
  localparam int unsigned LW    = ADDRB + 1;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             m_ready = 1'b1;
  logic [ADDRB-1:0] base_addr = '0;
  logic [ADDRB:0]   length = '0;
  logic             busy, done, mem_ena, mem_rea, m_valid, m_last;
  logic [ADDRB-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_douta, m_data;

  logic [WIDTH-1:0] sram [DEPTH];

  beat_t exp_q[$];
  int    hs_log[$];
  int    addr_log[$];
  int    checks = 0, errors = 0;
  int    cyc = 0;
  int    beats = 0, dones = 0, reas = 0, busys = 0;
  int    done_cyc = -1, st_cyc = 0;
  int    rdy_mode = 0;

  sram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRB(ADDRB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .mem_ena    (mem_ena),
    .mem_rea    (mem_rea),
    .mem_addr_o (mem_addr_o),
    .mem_douta  (mem_douta),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sp_sram stand-in, preloaded with mem[k] = k + 100
  initial begin
    mem_douta = '0;
    for (int k = 0; k < int'(DEPTH); k++) sram[k] = WIDTH'(k + 100);
  end
  always @(posedge clk) if (mem_ena && mem_rea) mem_douta <= sram[mem_addr_o];

  // m_ready driver: 0 = always 1, 1 = pattern 1,0,0,1, other = always 0
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor / scoreboard
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin dones++; done_cyc = cyc; end
      if (mem_rea) begin reas++; addr_log.push_back(int'(mem_addr_o)); end
      if (busy) busys++;
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready && !abort) begin
        beats++;
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_data), 32'(e.data));
          chk("beat_last", 32'(m_last), 32'(e.last));
        end
      end
    end
    prev_stall = rst_n && m_valid && !m_ready && !abort;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int b, input int l);
    beat_t e;
    for (int i = 0; i < l; i++) begin
      e.last = (i == l - 1);
      e.data = WIDTH'(((b + i) % int'(DEPTH)) + 100);
      exp_q.push_back(e);
    end
    base_addr = ADDRB'(b);
    length    = LW'(l);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    st_cyc    = cyc;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d0, r0, b0, bs0;
    int ea[4];

    // Reset
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_rea", 32'(mem_rea), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    // 1) base=5 len=4, ready held high
    hs_log.delete(); addr_log.delete(); d0 = dones; r0 = reas;
    issue(5, 4);
    wait_idle(50);
    repeat (2) tick();
    chk("t1_beats", 32'(hs_log.size()), 4);
    chk("t1_latency", 32'(hs_log[0] - st_cyc), 2);
    chk("t1_consecutive", 32'(hs_log[3] - hs_log[0]), 3);
    chk("t1_done_cycle", 32'(done_cyc - hs_log[3]), 1);
    chk("t1_done_count", 32'(dones - d0), 1);
    chk("t1_reads", 32'(reas - r0), 4);

    // 2) wrap: base=126 len=4
    addr_log.delete();
    issue(126, 4);
    wait_idle(50);
    repeat (2) tick();
    ea = '{126, 127, 0, 1};
    chk("t2_reads", 32'(addr_log.size()), 4);
    for (int i = 0; i < 4; i++) chk("t2_addr", 32'(addr_log[i]), 32'(ea[i]));

    // 3) len=8 with ready pattern 1,0,0,1
    hs_log.delete(); d0 = dones; r0 = reas;
    rdy_mode = 1;
    issue(20, 8);
    wait_idle(200);
    rdy_mode = 0;
    repeat (2) tick();
    chk("t3_beats", 32'(hs_log.size()), 8);
    chk("t3_reads", 32'(reas - r0), 8);
    chk("t3_done_count", 32'(dones - d0), 1);

    // 4) len=0
    d0 = dones; r0 = reas; b0 = beats; bs0 = busys;
    issue(7, 0);
    repeat (3) tick();
    chk("t4_done_count", 32'(dones - d0), 1);
    chk("t4_reads", 32'(reas - r0), 0);
    chk("t4_busy", 32'(busys - bs0), 0);
    chk("t4_beats", 32'(beats - b0), 0);

    // 5) len=10, abort after the 3rd beat, then base=0 len=2
    d0 = dones; b0 = beats;
    issue(40, 10);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (beats >= b0 + 3) break;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("t5_valid_drop", 32'(m_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    repeat (4) tick();
    chk("t5_no_done", 32'(dones - d0), 0);
    chk("t5_beats", 32'(beats - b0), 3);
    hs_log.delete();
    issue(0, 2);
    wait_idle(50);
    repeat (2) tick();
    chk("t5_restart_beats", 32'(hs_log.size()), 2);

    // 6) reset mid-transfer with the buffer full
    rdy_mode = 2;
    r0 = reas;
    issue(60, 8);
    repeat (8) tick();
    chk("t6_valid_held", 32'(m_valid), 1);
    chk("t6_credit_reads", 32'(reas - r0), 2);
    rst_n = 1'b0;
    tick();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_ena", 32'(mem_ena), 0);
    chk("t6_rea", 32'(mem_rea), 0);
    chk("t6_valid", 32'(m_valid), 0);
    chk("t6_last", 32'(m_last), 0);
    chk("t6_addr", 32'(mem_addr_o), 0);
    chk("t6_data", 32'(m_data), 0);
    rst_n = 1'b1;
    rdy_mode = 0;
    exp_q.delete();
    b0 = beats;
    repeat (10) tick();
    chk("t6_no_old_data", 32'(beats - b0), 0);
    chk("t6_idle", 32'(busy), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
